loader_sdram_bridge: RTL and testbench

- Sits between the game loader and the SDRAM controller write port during cartridge load.
- Buffers (address, byte) writes from the loader in a small FIFO.
- Replays each write into the SDRAM request interface, aligned to the NES clock-enable slot, so that each write is held stable for one full 4-cycle SDRAM request window.
- Replaces the single-entry trigger/latch logic in the top level. Back-to-back loader bytes arriving closer than 4 cycles apart are no longer lost.

---
 rtl/nes_loader_pkg.sv | 24 ++
 rtl/loader_fifo.sv | 79 +++++++
 rtl/loader_sdram_bridge.sv | 112 +++++++++++
 tb/tb_loader_sdram_bridge.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/nes_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : nes_loader_pkg
//  Description : Shared constants and the loader write record used by the
//                cartridge-load path into SDRAM.
//                  LOADER_ADDR_W - loader/SDRAM byte address width
//                  LOADER_DATA_W - loader write data width
//                  NES_CE_SLOT   - ce_phase value that opens a request window
//                  loader_wr_t   - packed {addr, data} write record
//  Revision    : 1.0 - initial release
// ============================================================================
package nes_loader_pkg;

    localparam int         LOADER_ADDR_W = 22;
    localparam int         LOADER_DATA_W = 8;
    localparam logic [1:0] NES_CE_SLOT   = 2'd3;

    typedef struct packed {
        logic [LOADER_ADDR_W-1:0] addr;
        logic [LOADER_DATA_W-1:0] data;
    } loader_wr_t;

endpackage : nes_loader_pkg
`default_nettype wire

// File: rtl/loader_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : loader_fifo
//  Description : Synchronous FIFO with asynchronous active-low reset. The read
//                data is the combinational head entry (no output register).
//  Ports       : clock   in   system clock
//                reset_n in   asynchronous active-low reset
//                push    in   write din (ignored when full)
//                pop     in   discard head entry (ignored when empty)
//                din     in   WIDTH write data
//                dout    out  WIDTH head entry
//                count   out  clog2(DEPTH)+1 occupancy
//                full    out  count == DEPTH
//                empty   out  count == 0
//  Revision    : 1.0 - initial release
// ============================================================================
module loader_fifo #(
    parameter  int WIDTH = 30,
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    localparam logic [CW-1:0] c_full_count = CW'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign full      = (r_count == c_full_count);
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign dout      = r_mem[r_rd_ptr];
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;

    // DEPTH is a power of two, so pointer wrap is the natural AW-bit rollover.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage is not reset; the pointers alone define which entries are valid.
    always_ff @(posedge clock) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

endmodule : loader_fifo
`default_nettype wire

// File: rtl/loader_sdram_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : loader_sdram_bridge
//  Description : Buffers loader byte writes and replays them into the SDRAM
//                write request port, one write per 4-cycle NES request
//                window, starting on the edge where ce_phase == SLOT.
//  Ports       : clock     in   system clock (21 MHz NES domain)
//                reset_n   in   asynchronous active-low reset
//                ce_phase  in   2   free-running clock-enable phase
//                load_done in   loader finished; pushes ignored when high
//                in_valid  in   loader write strobe
//                in_addr   in   ADDR_W loader byte address
//                in_data   in   DATA_W loader byte
//                in_ready  out  FIFO not full
//                mem_we    out  SDRAM write request, held for a whole window
//                mem_addr  out  ADDR_W SDRAM write address
//                mem_din   out  DATA_W SDRAM write data
//                overflow  out  sticky: a push was dropped on a full FIFO
//                idle      out  FIFO empty and no write in progress
//  Revision    : 1.0 - initial release
// ============================================================================
module loader_sdram_bridge
    import nes_loader_pkg::*;
#(
    parameter int         ADDR_W = LOADER_ADDR_W,
    parameter int         DATA_W = LOADER_DATA_W,
    parameter int         DEPTH  = 8,
    parameter logic [1:0] SLOT   = NES_CE_SLOT
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [1:0]        ce_phase,
    input  logic              load_done,
    input  logic              in_valid,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    output logic              overflow,
    output logic              idle
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int EW = ADDR_W + DATA_W;

    generate
        if (DEPTH < 2 || DEPTH > 64 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $error("loader_sdram_bridge: DEPTH must be a power of two in 2..64");
        end
    endgenerate

    logic          w_push_req;
    logic          w_push;
    logic          w_pop;
    logic          w_slot;
    logic          w_full;
    logic          w_empty;
    logic [CW-1:0] w_count;
    logic [EW-1:0] w_head;

    assign w_slot     = (ce_phase == SLOT);
    assign w_push_req = in_valid && !load_done;
    // Fullness is judged on the pre-edge occupancy, so a pop on the same edge
    // does not rescue a push into a full FIFO.
    assign w_push     = w_push_req && !w_full;
    assign w_pop      = w_slot && !w_empty;

    loader_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .push    (w_push),
        .pop     (w_pop),
        .din     ({in_addr, in_data}),
        .dout    (w_head),
        .count   (w_count),
        .full    (w_full),
        .empty   (w_empty)
    );

    // Request outputs only change on the slot edge, which makes every write
    // span exactly one 4-cycle window; back-to-back entries keep mem_we high.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mem_we   <= 1'b0;
            mem_addr <= '0;
            mem_din  <= '0;
        end else if (w_slot) begin
            mem_we <= !w_empty;
            if (!w_empty) begin
                {mem_addr, mem_din} <= w_head;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            overflow <= 1'b0;
        end else if (w_push_req && w_full) begin
            overflow <= 1'b1;
        end
    end

    assign in_ready = !w_full;
    assign idle     = (w_count == '0) && !mem_we;

endmodule : loader_sdram_bridge
`default_nettype wire

// File: tb/tb_loader_sdram_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : tb_loader_sdram_bridge
//  Description : Self-checking bench for loader_sdram_bridge. A queue holds
//                the writes expected to reach SDRAM; entries are pushed when
//                the bench drives an accepted byte and popped on slot edges.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_loader_sdram_bridge;
    import nes_loader_pkg::*;

    localparam int DEPTH = 8;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [1:0]  ce_phase;
    logic        load_done;
    logic        in_valid;
    logic [21:0] in_addr;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        mem_we;
    logic [21:0] mem_addr;
    logic [7:0]  mem_din;
    logic        overflow;
    logic        idle;

    int checks = 0;
    int errors = 0;

    loader_wr_t  q[$];
    logic        exp_we;
    logic [21:0] exp_addr;
    logic [7:0]  exp_din;
    logic        exp_ovf;
    int          we_high;
    int          run;
    int          last_run;

    always #5 clock = ~clock;

    loader_sdram_bridge #(
        .ADDR_W (LOADER_ADDR_W),
        .DATA_W (LOADER_DATA_W),
        .DEPTH  (DEPTH),
        .SLOT   (NES_CE_SLOT)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .ce_phase  (ce_phase),
        .load_done (load_done),
        .in_valid  (in_valid),
        .in_addr   (in_addr),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_din   (mem_din),
        .overflow  (overflow),
        .idle      (idle)
    );

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic model_reset();
        q.delete();
        exp_we   = 1'b0;
        exp_addr = '0;
        exp_din  = '0;
        exp_ovf  = 1'b0;
    endtask

    task automatic check_outputs();
        chk("mem_we",   32'(mem_we),   32'(exp_we));
        chk("mem_addr", 32'(mem_addr), 32'(exp_addr));
        chk("mem_din",  32'(mem_din),  32'(exp_din));
        chk("overflow", 32'(overflow), 32'(exp_ovf));
        chk("in_ready", 32'(in_ready), 32'(q.size() < DEPTH));
        chk("idle",     32'(idle),     32'(q.size() == 0 && !exp_we));
    endtask

    // Advance one clock: update the expected state from the inputs seen at
    // the edge, then compare every output 1 ns after the edge.
    task automatic tick();
        loader_wr_t e;
        bit         was_full;
        if (reset_n) begin
            was_full = (q.size() == DEPTH);
            if (ce_phase == NES_CE_SLOT) begin
                if (q.size() > 0) begin
                    e        = q.pop_front();
                    exp_we   = 1'b1;
                    exp_addr = e.addr;
                    exp_din  = e.data;
                end else begin
                    exp_we = 1'b0;
                end
            end
            if (in_valid && !load_done) begin
                if (was_full) exp_ovf = 1'b1;
                else          q.push_back({in_addr, in_data});
            end
        end
        @(posedge clock);
        #1;
        ce_phase = ce_phase + 2'd1;
        if (mem_we) begin
            we_high++;
            run++;
        end else begin
            if (run > 0) last_run = run;
            run = 0;
        end
        check_outputs();
    endtask

    task automatic idle_ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic align_phase(input logic [1:0] p);
        for (int i = 0; i < 4 && ce_phase != p; i++) tick();
    endtask

    task automatic push_seq(input int n, input logic [7:0] dbase, input logic [21:0] abase);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_addr  = abase + 22'(i);
            in_data  = dbase + 8'(i);
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        tick();
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n   = 1'b0;
        ce_phase  = 2'd0;
        load_done = 1'b0;
        in_valid  = 1'b0;
        in_addr   = '0;
        in_data   = '0;
        we_high   = 0;
        run       = 0;
        last_run  = 0;
        model_reset();

        // Reset state before any clock edge.
        #2;
        check_outputs();
        tick();
        reset_n = 1'b1;
        idle_ticks(3);

        // Single byte pushed on phase 0, issued on the phase-3 edge.
        align_phase(2'd0);
        we_high  = 0;
        in_valid = 1'b1;
        in_addr  = 22'h000010;
        in_data  = 8'hA5;
        tick();
        in_valid = 1'b0;
        idle_ticks(12);
        chk("single_window_len", 32'(we_high), 32'd4);
        chk("single_idle", 32'(idle), 32'd1);

        // Five back-to-back bytes form one contiguous 20-cycle request.
        last_run = 0;
        push_seq(5, 8'h01, 22'h000100);
        idle_ticks(30);
        chk("burst_run_len", 32'(last_run), 32'd20);
        chk("burst_no_ovf", 32'(overflow), 32'd0);

        // Twelve bytes from phase 0: FIFO fills, last two dropped (the final
        // one coincides with a pop at count == DEPTH).
        align_phase(2'd0);
        push_seq(12, 8'h10, 22'h000200);
        chk("ovf_set", 32'(overflow), 32'd1);
        idle_ticks(45);
        chk("ovf_sticky", 32'(overflow), 32'd1);
        chk("ovf_drained_idle", 32'(idle), 32'd1);

        do_reset();
        idle_ticks(2);

        // load_done blocks new pushes while buffered entries drain.
        we_high = 0;
        push_seq(3, 8'h30, 22'h000300);
        load_done = 1'b1;
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1;
            in_addr  = 22'h0003F0 + 22'(i);
            in_data  = 8'hE0 + 8'(i);
            tick();
        end
        in_valid = 1'b0;
        idle_ticks(15);
        chk("ld_write_cycles", 32'(we_high), 32'd12);
        chk("ld_no_ovf", 32'(overflow), 32'd0);
        chk("ld_idle", 32'(idle), 32'd1);
        load_done = 1'b0;

        // Asynchronous reset mid-window with four entries still buffered.
        align_phase(2'd0);
        push_seq(5, 8'h50, 22'h3F0000);
        chk("pre_rst_we", 32'(mem_we), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_rst_we", 32'(mem_we), 32'd0);
        chk("async_rst_addr", 32'(mem_addr), 32'd0);
        chk("async_rst_ready", 32'(in_ready), 32'd1);
        chk("async_rst_idle", 32'(idle), 32'd1);
        model_reset();
        tick();
        reset_n = 1'b1;
        we_high = 0;
        idle_ticks(20);
        chk("post_rst_no_write", 32'(we_high), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_loader_sdram_bridge
`default_nettype wire
